// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating counters beside fetch.
// Same-cycle lookup, registered training, saturating hit/mispredict stats.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pcF,
    output logic            predtakenF,
    output logic [PC_W-1:0] predtargetF,
    input  logic            updateD,
    input  logic [PC_W-1:0] pcD,
    input  logic            takenD,
    input  logic [PC_W-1:0] targetD,
    input  logic            predtakenD,
    input  logic [PC_W-1:0] predtargetD,
    input  logic            flushall,
    output logic            mispredictD,
    output logic [CNT_W-1:0] hitcnt,
    output logic [CNT_W-1:0] mispcnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic             validQ  [ENTRIES];
    logic [1:0]       ctrQ    [ENTRIES];
    logic [TAG_W-1:0] tagQ    [ENTRIES];
    logic [PC_W-1:0]  targetQ [ENTRIES];

    logic [IDX_W-1:0] idxF;
    logic [IDX_W-1:0] idxD;
    logic [TAG_W-1:0] tagF;
    logic [TAG_W-1:0] tagD;
    logic             hitF;
    logic             hitD;
    logic             writeEn;
    logic             allocEn;
    logic             unusedOk;

    assign idxF = pcF[IDX_W+1:2];
    assign tagF = pcF[PC_W-1:IDX_W+2];
    assign idxD = pcD[IDX_W+1:2];
    assign tagD = pcD[PC_W-1:IDX_W+2];

    // Word-aligned PCs: the low two bits never select anything.
    assign unusedOk = ^{pcF[1:0], pcD[1:0]};

    assign hitF = validQ[idxF] && (tagQ[idxF] == tagF);
    assign hitD = validQ[idxD] && (tagQ[idxD] == tagD);

    assign predtakenF  = hitF && ctrQ[idxF][1];
    assign predtargetF = hitF ? targetQ[idxF] : '0;

    assign mispredictD = updateD &&
        ((takenD != predtakenD) ||
         (takenD && predtakenD && (targetD != predtargetD)));

    assign writeEn = updateD && !flushall;
    assign allocEn = writeEn && takenD;

    // Valid bits and counters: flush wins, then train or allocate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i] <= 1'b0;
                ctrQ[i]   <= 2'b01;
            end
        end else if (flushall) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i] <= 1'b0;
            end
        end else if (writeEn) begin
            if (hitD) begin
                if (takenD && ctrQ[idxD] != 2'b11) begin
                    ctrQ[idxD] <= ctrQ[idxD] + 2'b01;
                end else if (!takenD && ctrQ[idxD] != 2'b00) begin
                    ctrQ[idxD] <= ctrQ[idxD] - 2'b01;
                end
            end else if (takenD) begin
                validQ[idxD] <= 1'b1;
                ctrQ[idxD]   <= 2'b10;
            end
        end
    end

    // Tags and targets need no reset: an invalid entry never hits.
    always_ff @(posedge clk) begin
        if (allocEn) begin
            tagQ[idxD]    <= tagD;
            targetQ[idxD] <= targetD;
        end
    end

    // Saturating statistics, counting straight through a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hitcnt  <= '0;
            mispcnt <= '0;
        end else begin
            if (hitF && hitcnt != '1) begin
                hitcnt <= hitcnt + CNT_W'(1);
            end
            if (mispredictD && mispcnt != '1) begin
                mispcnt <= mispcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor.
// Each vector is one cycle: inputs, same-cycle outputs, current stats.
module tb_branch_predictor;

    localparam logic [31:0] PA  = 32'h0040_0010;
    localparam logic [31:0] PB  = 32'h0040_0050;
    localparam logic [31:0] PC  = 32'h0040_0020;
    localparam logic [31:0] TA  = 32'h0040_0040;
    localparam logic [31:0] TA2 = 32'h0040_0080;
    localparam logic [31:0] TB  = 32'h0040_0100;
    localparam logic [31:0] Z   = 32'h0000_0000;

    logic        clk;
    logic        resetN;
    logic [31:0] pcF;
    logic        predtakenF;
    logic [31:0] predtargetF;
    logic        updateD;
    logic [31:0] pcD;
    logic        takenD;
    logic [31:0] targetD;
    logic        predtakenD;
    logic [31:0] predtargetD;
    logic        flushall;
    logic        mispredictD;
    logic [3:0]  hitcnt;
    logic [3:0]  mispcnt;

    int testsRun;
    int testsFailed;

    typedef struct {
        logic        upd;
        logic [31:0] pcD;
        logic        tk;
        logic [31:0] tgtD;
        logic        ptD;
        logic [31:0] ptgtD;
        logic        fl;
        logic [31:0] pcF;
        logic        expPt;
        logic [31:0] expTgt;
        logic        expMisp;
        int          expHit;
        int          expMispCnt;
    } vec_t;

    vec_t vq[$];

    branch_predictor #(
        .ENTRIES(16),
        .PC_W(32),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(resetN),
        .pcF(pcF),
        .predtakenF(predtakenF),
        .predtargetF(predtargetF),
        .updateD(updateD),
        .pcD(pcD),
        .takenD(takenD),
        .targetD(targetD),
        .predtakenD(predtakenD),
        .predtargetD(predtargetD),
        .flushall(flushall),
        .mispredictD(mispredictD),
        .hitcnt(hitcnt),
        .mispcnt(mispcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        updateD     = 1'b0;
        pcD         = Z;
        takenD      = 1'b0;
        targetD     = Z;
        predtakenD  = 1'b0;
        predtargetD = Z;
        flushall    = 1'b0;
        pcF         = Z;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        resetN      = 1'b0;
        idle();

        // upd pcD tk tgtD ptD ptgtD fl pcF | pt tgt misp hit mispcnt
        vq.push_back('{0, Z,  0, Z,   0, Z,   0, PA, 0, Z,   0, 0, 0});
        vq.push_back('{1, PA, 1, TA,  0, Z,   0, PA, 0, Z,   1, 0, 0});
        vq.push_back('{0, Z,  0, Z,   0, Z,   0, PA, 1, TA,  0, 0, 1});
        vq.push_back('{1, PA, 0, Z,   1, TA,  0, Z,  0, Z,   1, 1, 1});
        vq.push_back('{1, PA, 0, TB,  0, Z,   0, PA, 0, TA,  0, 1, 2});
        vq.push_back('{0, Z,  0, Z,   0, Z,   0, PA, 0, TA,  0, 2, 2});
        vq.push_back('{1, PA, 1, TA,  0, Z,   0, Z,  0, Z,   1, 3, 2});
        vq.push_back('{1, PA, 1, TA2, 0, Z,   0, PA, 0, TA,  1, 3, 3});
        vq.push_back('{1, PA, 1, TA2, 1, TA2, 0, PA, 1, TA2, 0, 4, 4});
        vq.push_back('{1, PA, 0, Z,   1, TA2, 0, Z,  0, Z,   1, 5, 4});
        vq.push_back('{0, Z,  0, Z,   0, Z,   0, PA, 1, TA2, 0, 5, 5});
        vq.push_back('{1, PA, 1, TA,  1, TA2, 0, Z,  0, Z,   1, 6, 5});
        vq.push_back('{1, PB, 1, TB,  0, Z,   0, PA, 1, TA,  1, 6, 6});
        vq.push_back('{0, Z,  0, Z,   0, Z,   0, PA, 0, Z,   0, 7, 7});
        vq.push_back('{0, Z,  0, Z,   0, Z,   0, PB, 1, TB,  0, 7, 7});
        vq.push_back('{1, PC, 0, TA,  0, Z,   0, PC, 0, Z,   0, 8, 7});
        vq.push_back('{0, Z,  0, Z,   0, Z,   0, PC, 0, Z,   0, 8, 7});
        vq.push_back('{1, PC, 1, TA,  0, Z,   1, PB, 1, TB,  1, 8, 7});
        vq.push_back('{0, Z,  0, Z,   0, Z,   0, PB, 0, Z,   0, 9, 8});
        vq.push_back('{0, Z,  0, Z,   0, Z,   0, PC, 0, Z,   0, 9, 8});
        vq.push_back('{0, Z,  0, Z,   0, Z,   0, PA, 0, Z,   0, 9, 8});

        nextCycle();
        pcF = PA;
        #1;
        check("reset_predtaken", {31'd0, predtakenF}, 32'd0);
        check("reset_predtarget", predtargetF, Z);
        check("reset_hitcnt", {28'd0, hitcnt}, 32'd0);
        check("reset_mispcnt", {28'd0, mispcnt}, 32'd0);
        nextCycle();
        resetN = 1'b1;
        idle();

        for (int i = 0; i < vq.size(); i++) begin
            updateD     = vq[i].upd;
            pcD         = vq[i].pcD;
            takenD      = vq[i].tk;
            targetD     = vq[i].tgtD;
            predtakenD  = vq[i].ptD;
            predtargetD = vq[i].ptgtD;
            flushall    = vq[i].fl;
            pcF         = vq[i].pcF;
            #1;
            check($sformatf("v%0d_predtaken", i),
                  {31'd0, predtakenF}, {31'd0, vq[i].expPt});
            check($sformatf("v%0d_predtarget", i),
                  predtargetF, vq[i].expTgt);
            check($sformatf("v%0d_mispredict", i),
                  {31'd0, mispredictD}, {31'd0, vq[i].expMisp});
            check($sformatf("v%0d_hitcnt", i),
                  {28'd0, hitcnt}, vq[i].expHit);
            check($sformatf("v%0d_mispcnt", i),
                  {28'd0, mispcnt}, vq[i].expMispCnt);
            nextCycle();
        end

        // Stats now hit=9, misp=8; allocate PA again (one mispredict).
        idle();
        updateD = 1'b1;
        pcD     = PA;
        takenD  = 1'b1;
        targetD = TA;
        nextCycle();

        // 20 mispredicts while looking up PA every cycle.
        pcD        = PC;
        takenD     = 1'b0;
        targetD    = Z;
        predtakenD = 1'b1;
        pcF        = PA;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (i == 0 || i == 19) begin
                check($sformatf("sat_misp_flag_%0d", i),
                      {31'd0, mispredictD}, 32'd1);
            end
            nextCycle();
        end
        check("sat_mispcnt", {28'd0, mispcnt}, 32'd15);
        check("sat_hitcnt", {28'd0, hitcnt}, 32'd15);
        check("sat_lookup_pa", {31'd0, predtakenF}, 32'd1);

        // Reset mid-stream with a taken update in flight.
        pcD     = PB;
        takenD  = 1'b1;
        targetD = TB;
        resetN  = 1'b0;
        #1;
        check("midrst_hitcnt", {28'd0, hitcnt}, 32'd0);
        check("midrst_mispcnt", {28'd0, mispcnt}, 32'd0);
        check("midrst_predtaken", {31'd0, predtakenF}, 32'd0);
        check("midrst_predtarget", predtargetF, Z);
        check("midrst_misp_follows", {31'd0, mispredictD}, 32'd1);
        nextCycle();
        nextCycle();
        idle();
        resetN = 1'b1;
        pcF    = PA;
        #1;
        check("postrst_pa_miss", predtargetF, Z);
        pcF = PB;
        #1;
        check("postrst_pb_miss", predtargetF, Z);
        nextCycle();
        check("postrst_hitcnt", {28'd0, hitcnt}, 32'd0);

        // First update after release is accepted at the first edge.
        updateD = 1'b1;
        pcD     = PC;
        takenD  = 1'b1;
        targetD = TA2;
        pcF     = PC;
        nextCycle();
        idle();
        pcF = PC;
        #1;
        check("postrst_alloc_taken", {31'd0, predtakenF}, 32'd1);
        check("postrst_alloc_target", predtargetF, TA2);
        check("postrst_mispcnt", {28'd0, mispcnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
